// File: rtl/iir_sos_tdm.sv
// Time-multiplexed cascade of Direct Form II biquads: one multiplier and one
// accumulator are stepped over NUM_SOS sections, five multiply phases each.
module iir_sos_tdm #(
  parameter int DATA_W  = 24,
  parameter int COEF_W  = 24,
  parameter int FRAC    = 22,
  parameter int NUM_SOS = 4,
  parameter int SEC_W   = (NUM_SOS > 1) ? $clog2(NUM_SOS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic [NUM_SOS-1:0] sos_bypass,
  input  logic               coef_we,
  input  logic [SEC_W+2:0]   coef_addr,
  input  logic [COEF_W-1:0]  coef_wdata,
  input  logic               state_clr,
  input  logic [SEC_W-1:0]   trace_sel,
  output logic [DATA_W-1:0]  trace_w1,
  output logic [DATA_W-1:0]  trace_w2,
  output logic [DATA_W-1:0]  trace_y
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 4;
  localparam int SL_B0  = 0;
  localparam int SL_B1  = 1;
  localparam int SL_B2  = 2;
  localparam int SL_A1  = 3;
  localparam int SL_A2  = 4;
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1'b1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = (ACC_W'(1'b1) << (DATA_W - 1)) - ACC_W'(1'b1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic [COEF_W-1:0]       COEF_ONE = COEF_W'(1'b1) << FRAC;

  function automatic logic [DATA_W-1:0] sat_rnd(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    r = (v + RND_HALF) >>> FRAC;
    if (r > SAT_MAX) begin
      sat_rnd = SAT_MAX[DATA_W-1:0];
    end else if (r < SAT_MIN) begin
      sat_rnd = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_rnd = r[DATA_W-1:0];
    end
  endfunction

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [SEC_W-1:0]         sec_q, sec_d;
  logic [2:0]               phase_q, phase_d;
  logic signed [DATA_W-1:0] x_q, x_d, w0_q, w0_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] w1_q [NUM_SOS];
  logic signed [DATA_W-1:0] w1_d [NUM_SOS];
  logic signed [DATA_W-1:0] w2_q [NUM_SOS];
  logic signed [DATA_W-1:0] w2_d [NUM_SOS];
  logic signed [DATA_W-1:0] ty_q [NUM_SOS];
  logic signed [DATA_W-1:0] ty_d [NUM_SOS];
  logic signed [COEF_W-1:0] coef_q [NUM_SOS][5];
  logic signed [COEF_W-1:0] coef_d [NUM_SOS][5];

  logic                     last_s, accept_s, coef_ok_s, byp_s, trace_ok_s;
  logic [SEC_W-1:0]         wsec_s;
  logic [2:0]               wslot_s;
  logic signed [COEF_W-1:0] mul_c_s;
  logic signed [DATA_W-1:0] mul_d_s, y_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s, x_ext_s, acc_sub_s, acc_add_s;

  assign last_s    = (phase_q == 3'd4) && (sec_q == SEC_W'(NUM_SOS - 1));
  assign accept_s  = in_valid && in_ready && !state_clr;
  assign coef_ok_s = coef_we && in_ready && !state_clr;
  assign wsec_s    = coef_addr[SEC_W+2:3];
  assign wslot_s   = coef_addr[2:0];
  assign byp_s     = sos_bypass[sec_q];

  assign prod_s     = $signed({{DATA_W{mul_c_s[COEF_W-1]}}, mul_c_s})
                    * $signed({{COEF_W{mul_d_s[DATA_W-1]}}, mul_d_s});
  assign prod_ext_s = $signed({{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s});
  assign x_ext_s    = $signed({{(ACC_W-DATA_W-FRAC){x_q[DATA_W-1]}}, x_q, {FRAC{1'b0}}});
  assign acc_sub_s  = acc_q - prod_ext_s;
  assign acc_add_s  = acc_q + prod_ext_s;
  assign y_s        = byp_s ? x_q : sat_rnd(acc_add_s);

  // State register of the sequencing FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clear aborts a run, the last P4 returns to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept_s ? S_RUN : S_IDLE;
      S_RUN:   state_d = (last_s || state_clr) ? S_IDLE : S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output: the engine accepts only while idle.
  always_comb begin
    in_ready = (state_q == S_IDLE);
  end

  // Shared multiplier operand selection per phase of the current section.
  always_comb begin
    mul_c_s = {COEF_W{1'b0}};
    mul_d_s = {DATA_W{1'b0}};
    case (phase_q)
      3'd0:    begin mul_c_s = coef_q[sec_q][SL_A1]; mul_d_s = w1_q[sec_q]; end
      3'd1:    begin mul_c_s = coef_q[sec_q][SL_A2]; mul_d_s = w2_q[sec_q]; end
      3'd2:    begin mul_c_s = coef_q[sec_q][SL_B0]; mul_d_s = w0_q;        end
      3'd3:    begin mul_c_s = coef_q[sec_q][SL_B1]; mul_d_s = w1_q[sec_q]; end
      3'd4:    begin mul_c_s = coef_q[sec_q][SL_B2]; mul_d_s = w2_q[sec_q]; end
      default: begin mul_c_s = {COEF_W{1'b0}};        mul_d_s = {DATA_W{1'b0}}; end
    endcase
  end

  // Datapath next state: accumulate, section hand-off, clear and coefficient writes.
  always_comb begin
    x_d = x_q; w0_d = w0_q; acc_d = acc_q; sec_d = sec_q; phase_d = phase_q;
    out_data_d = out_data_q; out_valid_d = 1'b0;
    w1_d = w1_q; w2_d = w2_q; ty_d = ty_q;
    if (state_clr) begin
      for (int s = 0; s < NUM_SOS; s++) begin
        w1_d[s] = {DATA_W{1'b0}};
        w2_d[s] = {DATA_W{1'b0}};
        ty_d[s] = {DATA_W{1'b0}};
      end
      sec_d   = {SEC_W{1'b0}};
      phase_d = 3'd0;
    end else if (accept_s) begin
      x_d     = in_data;
      sec_d   = {SEC_W{1'b0}};
      phase_d = 3'd0;
    end else if (state_q == S_RUN) begin
      case (phase_q)
        3'd0: begin acc_d = x_ext_s - prod_ext_s; phase_d = 3'd1; end
        3'd1: begin acc_d = acc_sub_s; w0_d = sat_rnd(acc_sub_s); phase_d = 3'd2; end
        3'd2: begin acc_d = prod_ext_s; phase_d = 3'd3; end
        3'd3: begin acc_d = acc_add_s;  phase_d = 3'd4; end
        3'd4: begin
          // A bypassed section forwards x and keeps its delay line frozen.
          ty_d[sec_q] = y_s;
          w1_d[sec_q] = byp_s ? w1_q[sec_q] : w0_q;
          w2_d[sec_q] = byp_s ? w2_q[sec_q] : w1_q[sec_q];
          x_d         = y_s;
          phase_d     = 3'd0;
          if (last_s) begin
            out_data_d  = y_s;
            out_valid_d = 1'b1;
            sec_d       = {SEC_W{1'b0}};
          end else begin
            sec_d = sec_q + SEC_W'(1'b1);
          end
        end
        default: phase_d = 3'd0;
      endcase
    end else begin
      x_d = x_q;
    end
    for (int s = 0; s < NUM_SOS; s++) begin
      for (int k = 0; k < 5; k++) begin
        coef_d[s][k] = (coef_ok_s && (wsec_s == SEC_W'(s)) && (wslot_s == 3'(k)))
                       ? coef_wdata : coef_q[s][k];
      end
    end
  end

  // Datapath registers; reset loads the identity coefficient set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q         <= {DATA_W{1'b0}};
      w0_q        <= {DATA_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      sec_q       <= {SEC_W{1'b0}};
      phase_q     <= 3'd0;
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      for (int s = 0; s < NUM_SOS; s++) begin
        w1_q[s] <= {DATA_W{1'b0}};
        w2_q[s] <= {DATA_W{1'b0}};
        ty_q[s] <= {DATA_W{1'b0}};
        coef_q[s][SL_B0] <= COEF_ONE;
        for (int k = 1; k < 5; k++) begin
          coef_q[s][k] <= {COEF_W{1'b0}};
        end
      end
    end else begin
      x_q         <= x_d;
      w0_q        <= w0_d;
      acc_q       <= acc_d;
      sec_q       <= sec_d;
      phase_q     <= phase_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      ty_q        <= ty_d;
      coef_q      <= coef_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign trace_ok_s = ({1'b0, trace_sel} < (SEC_W + 1)'(NUM_SOS));
  assign trace_w1   = trace_ok_s ? w1_q[trace_sel] : {DATA_W{1'b0}};
  assign trace_w2   = trace_ok_s ? w2_q[trace_sel] : {DATA_W{1'b0}};
  assign trace_y    = trace_ok_s ? ty_q[trace_sel] : {DATA_W{1'b0}};

endmodule
